// File: rtl/seq_radix4_booth_mult.sv
// Iterative radix-4 Booth multiplier: retires one Booth digit per clock into a shared
// accumulator, with valid/ready handshakes on both sides and a narrow-result overflow flag.
module seq_radix4_booth_mult #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               overflow,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam int MW = WIDTH + 3;
  localparam int CW = $clog2(WIDTH / 2 + 2);
  localparam logic [CW-1:0] LAST_S = CW'(WIDTH / 2 - 1);
  localparam logic [CW-1:0] LAST_U = CW'(WIDTH / 2);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] mcand_q, mcand_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [MW-1:0] mplr_q, mplr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          smode_q, smode_d;
  logic          ovf_q, ovf_d;
  logic [PW-1:0] pp;
  logic [PW-1:0] sum;
  logic          a_ext, b_ext;

  // Only the low 2*WIDTH bits of the product are observable, and two's-complement sums
  // are exact modulo 2^(2*WIDTH), so the multiplicand and accumulator stop at that width.
  // The multiplicand is pre-shifted by 2 each digit instead of shifting the partial product.
  always_comb begin
    a_ext = signed_mode & a[WIDTH-1];
    b_ext = signed_mode & b[WIDTH-1];
    pp    = '0;
    case (mplr_q[2:0])
      3'b001, 3'b010: pp = mcand_q;
      3'b011:         pp = mcand_q << 1;
      3'b100:         pp = -(mcand_q << 1);
      3'b101, 3'b110: pp = -mcand_q;
      default:        pp = '0;
    endcase
    sum = acc_q + pp;
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    mplr_d    = mplr_q;
    cnt_d     = cnt_q;
    smode_d   = smode_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mcand_d = {{(PW - WIDTH){a_ext}}, a};
          // Two extension bits above b, and the implicit b[-1]=0 below it.
          mplr_d  = {b_ext, b_ext, b, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
          smode_d = signed_mode;
          ovf_d   = 1'b0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d   = sum;
        mcand_d = mcand_q << 2;
        mplr_d  = {mplr_q[MW-1], mplr_q[MW-1], mplr_q[MW-1:2]};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == (smode_q ? LAST_S : LAST_U)) begin
          state_d = DONE;
          if (smode_q)
            ovf_d = !((&sum[PW-1:WIDTH-1]) || !(|sum[PW-1:WIDTH-1]));
          else
            ovf_d = |sum[PW-1:WIDTH];
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
      smode_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      mplr_q  <= mplr_d;
      cnt_q   <= cnt_d;
      smode_q <= smode_d;
      ovf_q   <= ovf_d;
    end
  end

  assign result   = acc_q;
  assign overflow = ovf_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_seq_radix4_booth_mult.sv
// Bench for seq_radix4_booth_mult: directed vectors plus a random sweep at WIDTH=32 and
// WIDTH=8, checked against plain integer multiplication.
module tb_seq_radix4_booth_mult;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        iv32, ir32, sm32, ov32, or32, of32, bz32;
  logic [31:0] a32, b32;
  logic [63:0] r32;
  logic        iv8, ir8, sm8, ov8, or8, of8, bz8;
  logic [7:0]  a8, b8;
  logic [15:0] r8;

  int checks = 0;
  int errors = 0;
  logic [63:0] last32;
  logic [15:0] last8;

  seq_radix4_booth_mult #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .signed_mode(sm32), .out_valid(ov32), .out_ready(or32), .result(r32),
    .overflow(of32), .busy(bz32)
  );

  seq_radix4_booth_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .signed_mode(sm8), .out_valid(ov8), .out_ready(or8), .result(r8),
    .overflow(of8), .busy(bz8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run32(input logic [31:0] ta, input logic [31:0] tbv, input logic ts,
                       input int stall);
    logic [63:0] exp;
    logic        eovf;
    longint      sp;
    int          cyc;
    if (ts) begin
      sp   = longint'($signed(ta)) * longint'($signed(tbv));
      exp  = sp;
      eovf = (sp > 64'sh7FFF_FFFF) || (sp < -64'sh8000_0000);
    end else begin
      exp  = {32'd0, ta} * {32'd0, tbv};
      eovf = (exp > 64'hFFFF_FFFF);
    end
    @(negedge clk);
    check("w32_in_ready_idle", 64'(ir32), 64'd1);
    a32 = ta; b32 = tbv; sm32 = ts; iv32 = 1'b1;
    @(negedge clk);
    check("w32_busy_calc", 64'(bz32), 64'd1);
    check("w32_in_ready_calc", 64'(ir32), 64'd0);
    // Operands wiggle with in_valid still high; none of it may be captured.
    a32 = $urandom; b32 = $urandom; sm32 = ~ts;
    or32 = (stall == 0);
    cyc = 0;
    while (!ov32 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("w32_latency", 64'(cyc), ts ? 64'd16 : 64'd17);
    check("w32_result", r32, exp);
    check("w32_overflow", 64'(of32), 64'(eovf));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("w32_hold_result", r32, exp);
      check("w32_hold_valid", 64'(ov32), 64'd1);
      check("w32_hold_in_ready", 64'(ir32), 64'd0);
    end
    last32 = r32;
    iv32 = 1'b0; or32 = 1'b1;
    @(negedge clk);
    or32 = 1'b0;
    check("w32_consumed_valid", 64'(ov32), 64'd0);
    check("w32_consumed_in_ready", 64'(ir32), 64'd1);
  endtask

  task automatic run8(input logic [7:0] ta, input logic [7:0] tbv, input logic ts,
                      input int stall);
    logic [15:0] exp;
    logic        eovf;
    int          p;
    int          cyc;
    if (ts) begin
      p    = int'($signed(ta)) * int'($signed(tbv));
      eovf = (p > 127) || (p < -128);
    end else begin
      p    = int'(ta) * int'(tbv);
      eovf = (p > 255);
    end
    exp = p[15:0];
    @(negedge clk);
    check("w8_in_ready_idle", 64'(ir8), 64'd1);
    a8 = ta; b8 = tbv; sm8 = ts; iv8 = 1'b1;
    @(negedge clk);
    a8 = 8'($urandom); b8 = 8'($urandom); sm8 = ~ts;
    or8 = (stall == 0);
    cyc = 0;
    while (!ov8 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("w8_latency", 64'(cyc), ts ? 64'd4 : 64'd5);
    check("w8_result", 64'(r8), 64'(exp));
    check("w8_overflow", 64'(of8), 64'(eovf));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("w8_hold_result", 64'(r8), 64'(exp));
    end
    last8 = r8;
    iv8 = 1'b0; or8 = 1'b1;
    @(negedge clk);
    or8 = 1'b0;
    check("w8_consumed_valid", 64'(ov8), 64'd0);
  endtask

  initial begin
    logic seen;
    rst_n = 1'b0;
    iv32 = 1'b0; or32 = 1'b0; sm32 = 1'b0; a32 = '0; b32 = '0;
    iv8 = 1'b0; or8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    #3;
    check("rst_in_ready", 64'(ir32), 64'd1);
    check("rst_out_valid", 64'(ov32), 64'd0);
    check("rst_busy", 64'(bz32), 64'd0);
    check("rst_result", r32, 64'd0);
    check("rst_overflow", 64'(of32), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run32(32'hFFFF_FFF9, 32'd3, 1'b1, 0);
    check("vec_neg7x3", last32, 64'hFFFF_FFFF_FFFF_FFEB);
    run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 2);
    check("vec_umax", last32, 64'hFFFF_FFFE_0000_0001);
    run32(32'h8000_0000, 32'h8000_0000, 1'b1, 0);
    check("vec_minneg_sq", last32, 64'h4000_0000_0000_0000);
    run32(32'd1234567, 32'd7654321, 1'b0, 5);

    // Abort an operation part-way through CALC with an asynchronous reset.
    @(negedge clk);
    a32 = 32'd123456; b32 = 32'hFFFF_FCEB; sm32 = 1'b1; iv32 = 1'b1;
    @(negedge clk);
    iv32 = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_in_ready", 64'(ir32), 64'd1);
    check("abort_out_valid", 64'(ov32), 64'd0);
    check("abort_busy", 64'(bz32), 64'd0);
    check("abort_result", r32, 64'd0);
    check("abort_overflow", 64'(of32), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | ov32;
    end
    check("abort_no_result", 64'(seen), 64'd0);
    run32(32'd5, 32'hFFFF_FFFC, 1'b1, 0);
    check("vec_5xneg4", last32, 64'hFFFF_FFFF_FFFF_FFEC);

    run8(8'h80, 8'h7F, 1'b1, 0);
    check("vec8_minxmax", 64'(last8), 64'h0000_0000_0000_C080);
    run8(8'h80, 8'h80, 1'b1, 1);
    run8(8'hFF, 8'hFF, 1'b0, 0);

    for (int i = 0; i < 20; i++)
      run32($urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    for (int i = 0; i < 30; i++)
      run8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
